// File: rtl/sd_cmd_serializer.sv
// SD command frame serializer.
// Takes a latched command through a start/busy/done handshake, builds the 48-bit frame
// {0, 1, index[5:0], arg[31:0], crc7[6:0], 1} and shifts it MSB-first onto the CMD line,
// one bit per enable tick. The CRC7 is accumulated while the first 40 bits go out.
// Response attributes are latched at accept and held for the response receiver.
module sd_cmd_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_start,
  input  logic [5:0]  CommandIndex_in,
  input  logic [31:0] Argument_in,
  input  logic [1:0]  CommandType_in,
  input  logic        DataPresentState_in,
  input  logic        CommandIndezCheckEnable_in,
  input  logic        CommandCRCCheckEnable_in,
  input  logic [1:0]  ResponseTypeSelect_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic        resp_expected,
  output logic        resp_long,
  output logic [1:0]  CommandType_q,
  output logic        DataPresentState_q,
  output logic        IndexChk_q,
  output logic        CRCChk_q,
  output logic [1:0]  RespType_q
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StCrc  = 2'd2;
  localparam logic [1:0] StEnd  = 2'd3;

  logic [1:0]  state;
  logic [39:0] shreg;
  logic [6:0]  crc;
  logic [5:0]  bit_cnt;
  logic        crc_fb;
  logic [6:0]  crc_upd;

  // CRC7 (x^7 + x^3 + 1) step for the bit currently on the line.
  always_comb begin
    crc_fb  = crc[6] ^ shreg[39];
    crc_upd = {crc[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
  end

  // Frame sequencer: accept, shift header, shift CRC, end bit, done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= StIdle;
      shreg              <= '0;
      crc                <= '0;
      bit_cnt            <= '0;
      cmd_out            <= 1'b1;
      cmd_oe             <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      resp_expected      <= 1'b0;
      resp_long          <= 1'b0;
      CommandType_q      <= '0;
      DataPresentState_q <= 1'b0;
      IndexChk_q         <= 1'b0;
      CRCChk_q           <= 1'b0;
      RespType_q         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_start) begin
            state              <= StSend;
            shreg              <= {2'b01, CommandIndex_in, Argument_in};
            crc                <= '0;
            bit_cnt            <= '0;
            cmd_out            <= 1'b0;  // start bit
            cmd_oe             <= 1'b1;
            busy               <= 1'b1;
            CommandType_q      <= CommandType_in;
            DataPresentState_q <= DataPresentState_in;
            IndexChk_q         <= CommandIndezCheckEnable_in;
            CRCChk_q           <= CommandCRCCheckEnable_in;
            RespType_q         <= ResponseTypeSelect_in;
            resp_expected      <= (ResponseTypeSelect_in != 2'b00);
            resp_long          <= (ResponseTypeSelect_in == 2'b01);
          end
        end
        StSend: begin
          if (enable) begin
            crc     <= crc_upd;
            shreg   <= {shreg[38:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd39) begin
              state   <= StCrc;
              cmd_out <= crc_upd[6];  // first CRC bit comes straight from the final update
            end else begin
              cmd_out <= shreg[38];
            end
          end
        end
        StCrc: begin
          if (enable) begin
            crc     <= {crc[5:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd46) begin
              state   <= StEnd;
              cmd_out <= 1'b1;  // end bit
            end else begin
              cmd_out <= crc[5];
            end
          end
        end
        StEnd: begin
          if (enable) begin
            state   <= StIdle;
            done    <= 1'b1;
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Self-checking bench for sd_cmd_serializer: directed frames from known SD commands plus
// randomized frames checked against a frame-level reference (header + CRC7 + end bit).
module tb_sd_cmd_serializer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  idx_in = '0;
  logic [31:0] arg_in = '0;
  logic [1:0]  ct_in = '0;
  logic        dps_in = 1'b0;
  logic        ich_in = 1'b0;
  logic        cch_in = 1'b0;
  logic [1:0]  rts_in = '0;

  logic        cmd_out, cmd_oe, busy, done, resp_expected, resp_long;
  logic [1:0]  CommandType_q, RespType_q;
  logic        DataPresentState_q, IndexChk_q, CRCChk_q;

  int total = 0;
  int bad = 0;

  sd_cmd_serializer dut (
    .clock                      (clock),
    .reset                      (reset),
    .enable                     (enable),
    .cmd_start                  (cmd_start),
    .CommandIndex_in            (idx_in),
    .Argument_in                (arg_in),
    .CommandType_in             (ct_in),
    .DataPresentState_in        (dps_in),
    .CommandIndezCheckEnable_in (ich_in),
    .CommandCRCCheckEnable_in   (cch_in),
    .ResponseTypeSelect_in      (rts_in),
    .cmd_out                    (cmd_out),
    .cmd_oe                     (cmd_oe),
    .busy                       (busy),
    .done                       (done),
    .resp_expected              (resp_expected),
    .resp_long                  (resp_long),
    .CommandType_q              (CommandType_q),
    .DataPresentState_q         (DataPresentState_q),
    .IndexChk_q                 (IndexChk_q),
    .CRCChk_q                   (CRCChk_q),
    .RespType_q                 (RespType_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference frame: header bits, CRC7 over them by polynomial division, end bit.
  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ h[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {h, c, 1'b1};
  endfunction

  function automatic logic [6:0] pack_q(input logic [1:0] ct, input logic dps, input logic ich,
                                        input logic cch, input logic [1:0] rts);
    return {ct, dps, ich, cch, rts};
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_out"}, cmd_out, 1'b1);
    chk({tag, "_oe"}, cmd_oe, 1'b0);
    chk({tag, "_busy_done"}, {busy, done}, 2'b00);
    chk({tag, "_q"}, {resp_expected, resp_long, CommandType_q, DataPresentState_q, IndexChk_q,
                      CRCChk_q, RespType_q}, 9'd0);
  endtask

  // Sends one frame. period: enable high 1 clock in period. mid_at: cycle at which a stray
  // cmd_start is pulsed (-1 none). rst_at: bit index at which reset is asserted (-1 none).
  task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rts, input logic [1:0] ct, input logic dps,
                           input logic ich, input logic cch, input int period,
                           input int mid_at, input int rst_at, input logic [47:0] exp_frame);
    logic [47:0] cap;
    int adv, oe_cnt, done_cnt, hold_err, ovl, limit;
    bit aborted, done_checked;
    logic [6:0] exp_q;
    exp_q = pack_q(ct, dps, ich, cch, rts);
    @(negedge clock);
    idx_in = idx; arg_in = arg; rts_in = rts; ct_in = ct;
    dps_in = dps; ich_in = ich; cch_in = cch;
    cmd_start = 1'b1;
    enable = 1'b1;  // enable on the accept edge must not advance
    @(posedge clock); #1;
    chk({tag, "_acc_state"}, {busy, cmd_oe, cmd_out, done}, 4'b1100);
    chk({tag, "_acc_q"}, pack_q(CommandType_q, DataPresentState_q, IndexChk_q, CRCChk_q,
                                RespType_q), exp_q);
    chk({tag, "_acc_resp"}, {resp_expected, resp_long}, {rts != 2'b00, rts == 2'b01});
    cap = '1;
    cap[47] = cmd_out;
    adv = 0; oe_cnt = 1; done_cnt = 0; hold_err = 0; ovl = 0;
    aborted = 0; done_checked = 0;
    limit = 52 * period + 4;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clock);
      cmd_start = (cyc == mid_at);
      idx_in = 6'($urandom); arg_in = $urandom; rts_in = 2'($urandom); ct_in = 2'($urandom);
      dps_in = 1'($urandom); ich_in = 1'($urandom); cch_in = 1'($urandom);
      enable = ((cyc % period) == period - 1);
      if (rst_at >= 0 && adv == rst_at) begin
        #2 reset = 1'b0;
        #1;
        check_reset_state({tag, "_rst"});
        @(negedge clock);
        reset = 1'b1;
        cmd_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clock); #1;
          done_cnt += int'(done);
        end
        chk({tag, "_rst_nodone"}, done_cnt, 0);
        chk({tag, "_rst_idle"}, {busy, cmd_oe, cmd_out}, 3'b001);
        aborted = 1;
        break;
      end
      @(posedge clock); #1;
      if (enable && adv < 48) adv++;
      if (adv < 48) begin
        cap[47-adv] = cmd_out;
        if (cmd_out !== exp_frame[47-adv]) hold_err++;
      end else if (!done_checked) begin
        done_checked = 1;
        chk({tag, "_done_pulse"}, {done, busy, cmd_oe, cmd_out}, 4'b1001);
      end
      oe_cnt += int'(cmd_oe);
      done_cnt += int'(done);
      if (done && busy) ovl++;
    end
    if (!aborted) begin
      chk({tag, "_stream"}, cap, exp_frame);
      chk({tag, "_hold_err"}, hold_err, 0);
      chk({tag, "_oe_clocks"}, oe_cnt, 48 * period);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_done_busy"}, ovl, 0);
      chk({tag, "_bound"}, done_checked, 1'b1);
      chk({tag, "_post_q"}, pack_q(CommandType_q, DataPresentState_q, IndexChk_q, CRCChk_q,
                                   RespType_q), exp_q);
      chk({tag, "_post_resp"}, {resp_expected, resp_long}, {rts != 2'b00, rts == 2'b01});
    end
    @(negedge clock);
    cmd_start = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    logic [5:0]  ri;
    logic [31:0] ra;
    #12;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("idle");

    run_frame("cmd0", 6'd0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1, -1, -1,
              48'h40_0000_0000_95);
    run_frame("cmd8", 6'd8, 32'h0000_01AA, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 1, -1, -1,
              48'h48_0000_01AA_87);
    run_frame("cmd17_div4", 6'd17, 32'h0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4, -1, -1,
              48'h51_0000_0000_55);
    run_frame("mid_start", 6'd8, 32'h0000_01AA, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1, 10, -1,
              48'h48_0000_01AA_87);
    ra = $urandom;
    run_frame("rst_bit20", 6'd5, ra, 2'b10, 2'b11, 1'b1, 1'b1, 1'b1, 1, -1, 20,
              ref_frame(6'd5, ra));
    run_frame("cmd0_after_rst", 6'd0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1, -1, -1,
              48'h40_0000_0000_95);
    ra = $urandom;
    run_frame("cmd2_long", 6'd2, ra, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 1, -1, -1,
              ref_frame(6'd2, ra));
    for (int n = 0; n < 6; n++) begin
      ri = 6'($urandom);
      ra = $urandom;
      run_frame($sformatf("rand%0d", n), ri, ra, 2'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(1, 3)), -1, -1,
                ref_frame(ri, ra));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
